fp_max_scan: RTL

Sequencer that streams a block of 13-bit floating-point words through the team's FP greater-than compare and returns the block maximum and its index. The format is {sign, exp[3:0], frac[7:0]}. It sits between an operand source (valid/ready stream) and a result consumer (valid/ready). It owns all sequencing: the length latch, the element counter, the running max and the result hold.

---
 rtl/fp_comp_pkg.sv | 30 +++
 rtl/fp_gt.sv | 38 +++
 rtl/fp_max_scan.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fp_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_comp_pkg
// Description : Shared constants for the 13-bit FP compare/scan block:
//               field widths, field bit positions and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_comp_pkg;

    // Word format {sign, exp[3:0], frac[7:0]}
    localparam int FP_W   = 13;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;
    localparam int MAG_W  = EXP_W + FRAC_W;

    // Field bit positions
    localparam int SIGN_BIT = 12;
    localparam int EXP_HI   = 11;
    localparam int EXP_LO   = 8;
    localparam int FRAC_HI  = 7;
    localparam int FRAC_LO  = 0;

    // Scan sequencer state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FIRST = 2'd1;
    localparam logic [1:0] c_ST_SCAN  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

endpackage : fp_comp_pkg
`default_nettype wire

// File: rtl/fp_gt.sv
`default_nettype none
// ============================================================================
// Module      : fp_gt
// Description : Combinational strict greater-than for 13-bit sign/magnitude
//               FP words. +0 and -0 compare equal.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_gt
    import fp_comp_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic            o_gt
);

    logic             w_a_sign;
    logic             w_b_sign;
    logic [MAG_W-1:0] w_a_mag;
    logic [MAG_W-1:0] w_b_mag;

    // {exp, frac} is monotonic in magnitude, so magnitudes compare unsigned
    always_comb begin
        w_a_sign = i_a[SIGN_BIT];
        w_b_sign = i_b[SIGN_BIT];
        w_a_mag  = i_a[EXP_HI:FRAC_LO];
        w_b_mag  = i_b[EXP_HI:FRAC_LO];
        o_gt     = 1'b0;
        case ({w_a_sign, w_b_sign})
            2'b00:   o_gt = (w_a_mag > w_b_mag);
            2'b11:   o_gt = (w_a_mag < w_b_mag);
            // a positive, b negative: greater unless both are zero
            2'b01:   o_gt = !((w_a_mag == '0) && (w_b_mag == '0));
            default: o_gt = 1'b0;
        endcase
    end

endmodule : fp_gt
`default_nettype wire

// File: rtl/fp_max_scan.sv
`default_nettype none
// ============================================================================
// Module      : fp_max_scan
// Description : Streams a block of 1..N_MAX FP words through fp_gt and
//               returns the block maximum and the index of its first
//               occurrence over a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_max_scan
    import fp_comp_pkg::*;
#(
    parameter int N_MAX = 16,
    parameter int IDX_W = 4,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [FP_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [FP_W-1:0]  out_max,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [FP_W-1:0]  r_max;
    logic [IDX_W-1:0] r_idx;
    logic             r_err;
    logic             w_err_next;
    logic             w_len_ok;
    logic             w_accept;
    logic             w_gt;
    logic             w_last_beat;

    assign w_len_ok    = (len != '0) && (len <= LEN_W'(N_MAX));
    assign w_accept    = in_valid && ((r_state == c_ST_FIRST) || (r_state == c_ST_SCAN));
    assign w_last_beat = (r_cnt == (r_len - LEN_W'(1)));

    assign out_max = r_max;
    assign out_idx = r_idx;
    assign err     = r_err;

    fp_gt u_fp_gt (
        .i_a  (in_data),
        .i_b  (r_max),
        .o_gt (w_gt)
    );

    // State register and the registered illegal-length pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state and handshake outputs; abort overrides every other event
    always_comb begin
        w_state_next = r_state;
        w_err_next   = 1'b0;
        in_ready     = (r_state == c_ST_FIRST) || (r_state == c_ST_SCAN);
        out_valid    = (r_state == c_ST_DONE);
        busy         = (r_state != c_ST_IDLE);
        if (abort) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (w_len_ok) w_state_next = c_ST_FIRST;
                        else          w_err_next   = 1'b1;
                    end
                end
                c_ST_FIRST: begin
                    if (w_accept) begin
                        w_state_next = (r_len == LEN_W'(1)) ? c_ST_DONE : c_ST_SCAN;
                    end
                end
                c_ST_SCAN: begin
                    if (w_accept && w_last_beat) w_state_next = c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (out_ready) w_state_next = c_ST_IDLE;
                end
                default: w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // Length latch, element counter and running max/index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_cnt <= '0;
            r_max <= '0;
            r_idx <= '0;
        end else if (!abort) begin
            if ((r_state == c_ST_IDLE) && start && w_len_ok) begin
                r_len <= len;
                r_cnt <= '0;
            end
            if (w_accept && (r_state == c_ST_FIRST)) begin
                r_max <= in_data;
                r_idx <= '0;
                r_cnt <= LEN_W'(1);
            end else if (w_accept && (r_state == c_ST_SCAN)) begin
                // Strict compare: ties keep the earlier index
                if (w_gt) begin
                    r_max <= in_data;
                    r_idx <= r_cnt[IDX_W-1:0];
                end
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

endmodule : fp_max_scan
`default_nettype wire
